// File: rtl/load_use_if.sv
// ID-stage hazard bus between the decode/issue logic and the load-use scoreboard.
interface load_use_if #(
  parameter int CNT_W = 32
);
  logic             issue_i;
  logic             issue_RegWrite_i;
  logic             issue_MemRead_i;
  logic [4:0]       issue_rd_i;
  logic [4:0]       rs1_ID_i;
  logic [4:0]       rs2_ID_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic             load_done_i;
  logic [4:0]       load_done_rd_i;
  logic             mem_stall_i;
  logic             stall_o;
  logic [31:0]      pending_o;
  logic [1:0]       outstanding_o;
  logic             overflow_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] stall_events_o;

  modport master (
    output issue_i, issue_RegWrite_i, issue_MemRead_i, issue_rd_i,
    output rs1_ID_i, rs2_ID_i, rs1_used_i, rs2_used_i,
    output load_done_i, load_done_rd_i, mem_stall_i,
    input  stall_o, pending_o, outstanding_o, overflow_o,
    input  stall_cycles_o, stall_events_o
  );

  modport slave (
    input  issue_i, issue_RegWrite_i, issue_MemRead_i, issue_rd_i,
    input  rs1_ID_i, rs2_ID_i, rs1_used_i, rs2_used_i,
    input  load_done_i, load_done_rd_i, mem_stall_i,
    output stall_o, pending_o, outstanding_o, overflow_o,
    output stall_cycles_o, stall_events_o
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// Pending-load scoreboard: stalls the instruction in ID while a source register
// still awaits load data from the data cache.
module load_use_scoreboard #(
  parameter int MAX_LOADS = 2,
  parameter int CNT_W     = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  load_use_if.slave  bus
);
  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [1:0] MAX_L = 2'(MAX_LOADS);

  logic [31:0]      pending_q, pending_d;
  logic [1:0]       outstanding_q, outstanding_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] stall_events_q, stall_events_d;

  logic ld_issue, set_en, clr_en, haz_rs1, haz_rs2, stall, cnt_en;

  // x0 loads still occupy a cache slot, so they count as in flight
  assign ld_issue = bus.issue_i & ~bus.mem_stall_i & bus.issue_RegWrite_i & bus.issue_MemRead_i;
  assign set_en   = ld_issue & (bus.issue_rd_i != 5'd0);
  assign clr_en   = bus.load_done_i & (bus.load_done_rd_i != 5'd0);

  // A load returning this cycle reaches MEM/WB at the edge, so forwarding covers it
  assign haz_rs1 = bus.rs1_used_i & (bus.rs1_ID_i != 5'd0) & pending_q[bus.rs1_ID_i]
                 & ~(clr_en & (bus.load_done_rd_i == bus.rs1_ID_i));
  assign haz_rs2 = bus.rs2_used_i & (bus.rs2_ID_i != 5'd0) & pending_q[bus.rs2_ID_i]
                 & ~(clr_en & (bus.load_done_rd_i == bus.rs2_ID_i));
  assign stall   = haz_rs1 | haz_rs2;
  assign cnt_en  = stall & ~bus.mem_stall_i;

  always_comb begin
    pending_d      = pending_q;
    outstanding_d  = outstanding_q;
    overflow_d     = overflow_q;
    state_d        = state_q;
    stall_cycles_d = stall_cycles_q;
    stall_events_d = stall_events_q;

    // Clear first so a same-register set in the same cycle wins
    if (clr_en) pending_d[bus.load_done_rd_i] = 1'b0;
    if (set_en) pending_d[bus.issue_rd_i]     = 1'b1;
    pending_d[0] = 1'b0;

    case ({ld_issue, bus.load_done_i})
      2'b10: begin
        if (outstanding_q == MAX_L) overflow_d    = 1'b1;
        else                        outstanding_d = outstanding_q + 2'd1;
      end
      2'b01: begin
        if (outstanding_q == 2'd0) overflow_d    = 1'b1;
        else                       outstanding_d = outstanding_q - 2'd1;
      end
      default: ;
    endcase

    case (state_q)
      RUN: begin
        if (cnt_en) begin
          state_d = HOLD;
          if (~&stall_events_q) stall_events_d = stall_events_q + 1'b1;
        end
      end
      HOLD: if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (cnt_en && ~&stall_cycles_q) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q      <= '0;
      outstanding_q  <= '0;
      overflow_q     <= 1'b0;
      state_q        <= RUN;
      stall_cycles_q <= '0;
      stall_events_q <= '0;
    end else begin
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      overflow_q     <= overflow_d;
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      stall_events_q <= stall_events_d;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.pending_o      = pending_q;
  assign bus.outstanding_o  = outstanding_q;
  assign bus.overflow_o     = overflow_q;
  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.stall_events_o = stall_events_q;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Scoreboard bench: expectations are queued when a cycle is driven and compared
// on the following falling edge.
module tb_load_use_scoreboard;
  localparam int CW = 3;  // narrow counters so saturation is reachable
  localparam int S_STALL = 0, S_PEND = 1, S_OUTS = 2, S_OVF = 3, S_CYC = 4, S_EVT = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  load_use_if #(.CNT_W(CW)) bus ();

  load_use_scoreboard #(.MAX_LOADS(2), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ex(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] obs;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          S_STALL: obs = {31'd0, bus.stall_o};
          S_PEND:  obs = bus.pending_o;
          S_OUTS:  obs = 32'(bus.outstanding_o);
          S_OVF:   obs = {31'd0, bus.overflow_o};
          S_CYC:   obs = 32'(bus.stall_cycles_o);
          default: obs = 32'(bus.stall_events_o);
        endcase
        chk(e.tag, obs, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_i = 0; bus.issue_RegWrite_i = 0; bus.issue_MemRead_i = 0; bus.issue_rd_i = 0;
    bus.rs1_ID_i = 0; bus.rs2_ID_i = 0; bus.rs1_used_i = 0; bus.rs2_used_i = 0;
    bus.load_done_i = 0; bus.load_done_rd_i = 0; bus.mem_stall_i = 0;
  endtask

  task automatic ld(input logic [4:0] rd);
    bus.issue_i = 1; bus.issue_RegWrite_i = 1; bus.issue_MemRead_i = 1; bus.issue_rd_i = rd;
  endtask

  task automatic done(input logic [4:0] rd);
    bus.load_done_i = 1; bus.load_done_rd_i = rd;
  endtask

  task automatic rd1(input logic [4:0] r, input logic u);
    bus.rs1_ID_i = r; bus.rs1_used_i = u;
  endtask

  task automatic rd2(input logic [4:0] r, input logic u);
    bus.rs2_ID_i = r; bus.rs2_used_i = u;
  endtask

  // Reset with a load driven during it; the cycle after must show reset state
  task automatic rst_pulse();
    idle(); rst = 1; ld(5'd3); tick();
    rst = 0; idle();
    ex("rst_stall", S_STALL, 0); ex("rst_pend", S_PEND, 0); ex("rst_outs", S_OUTS, 0);
    ex("rst_ovf", S_OVF, 0); ex("rst_cyc", S_CYC, 0); ex("rst_evt", S_EVT, 0);
    tick();
  endtask

  initial begin
    idle();
    tick();
    rst_pulse();

    // load-use, cache hit
    ld(5'd5); ex("hit_c1_stall", S_STALL, 0); tick();
    idle(); rd1(5'd5, 1); rd2(5'd1, 1);
    ex("hit_c2_stall", S_STALL, 1); ex("hit_c2_pend", S_PEND, 32'h20); ex("hit_c2_outs", S_OUTS, 1); tick();
    done(5'd5);
    ex("hit_c3_stall", S_STALL, 0); ex("hit_c3_pend", S_PEND, 32'h20);
    ex("hit_c3_cyc", S_CYC, 1); ex("hit_c3_evt", S_EVT, 1); tick();
    idle(); rd1(5'd5, 1); rd2(5'd1, 1);
    ex("hit_c4_stall", S_STALL, 0); ex("hit_c4_pend", S_PEND, 0); ex("hit_c4_outs", S_OUTS, 0);
    ex("hit_c4_cyc", S_CYC, 1); ex("hit_c4_evt", S_EVT, 1); tick();

    // cache miss: done delayed to cycle 12, frozen 3..11
    rst_pulse();
    ld(5'd5); tick();
    idle(); rd1(5'd5, 1); rd2(5'd1, 1); ex("miss_c2_stall", S_STALL, 1); tick();
    for (int c = 3; c <= 11; c++) begin
      bus.mem_stall_i = 1;
      ex("miss_frozen_stall", S_STALL, 1); ex("miss_frozen_pend", S_PEND, 32'h20);
      if (c == 11) ex("miss_c11_cyc", S_CYC, 1);
      tick();
    end
    bus.mem_stall_i = 0; done(5'd5);
    ex("miss_c12_stall", S_STALL, 0); ex("miss_c12_pend", S_PEND, 32'h20); tick();
    idle();
    ex("miss_c13_pend", S_PEND, 0); ex("miss_c13_cyc", S_CYC, 1); ex("miss_c13_evt", S_EVT, 1); tick();

    // same-register collision, then different registers in one cycle
    rst_pulse();
    ld(5'd7); tick();
    ld(5'd7); done(5'd7); ex("col_b_outs", S_OUTS, 1); tick();
    idle(); ld(5'd8); done(5'd7);
    ex("col_c_pend", S_PEND, 32'h80); ex("col_c_outs", S_OUTS, 1); tick();
    idle(); ex("diff_pend", S_PEND, 32'h100); ex("diff_outs", S_OUTS, 1); tick();

    // x0 load, unused/x0 sources, issue ignored while frozen
    rst_pulse();
    ld(5'd0); tick();
    ld(5'd9); ex("x0_pend", S_PEND, 0); ex("x0_outs", S_OUTS, 1); tick();
    idle(); rd1(5'd0, 1); rd2(5'd9, 0);
    ex("unused_stall", S_STALL, 0); ex("x9_pend", S_PEND, 32'h200); ex("x9_outs", S_OUTS, 2); tick();
    rd2(5'd9, 1); ld(5'd10); bus.mem_stall_i = 1;
    ex("used_stall", S_STALL, 1); tick();
    idle();
    ex("frz_pend", S_PEND, 32'h200); ex("frz_outs", S_OUTS, 2);
    ex("frz_cyc", S_CYC, 0); ex("frz_evt", S_EVT, 0); tick();

    // overflow on both ends, sticky until reset
    rst_pulse();
    ld(5'd1); tick();
    ld(5'd2); tick();
    ld(5'd3); ex("ovf_pre", S_OVF, 0); ex("ovf_pre_outs", S_OUTS, 2); tick();
    idle(); done(5'd1);
    ex("ovf_outs", S_OUTS, 2); ex("ovf_flag", S_OVF, 1); ex("ovf_pend", S_PEND, 32'hE); tick();
    done(5'd2); tick();
    done(5'd3); ex("undf_outs0", S_OUTS, 0); tick();
    idle(); ex("undf_outs", S_OUTS, 0); ex("ovf_sticky", S_OVF, 1); ex("undf_pend", S_PEND, 0); tick();
    rst_pulse();

    // reset while stalled
    ld(5'd4); tick();
    idle(); rd1(5'd4, 1); rst = 1; ld(5'd6); ex("rstmid_pre", S_STALL, 1); tick();
    rst = 0; idle(); rd1(5'd4, 1);
    ex("rstmid_stall", S_STALL, 0); ex("rstmid_pend", S_PEND, 0); ex("rstmid_outs", S_OUTS, 0);
    ex("rstmid_cyc", S_CYC, 0); ex("rstmid_evt", S_EVT, 0); tick();

    // counter saturation
    rst_pulse();
    ld(5'd5); tick();
    idle(); rd1(5'd5, 1);
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < 9; i++) begin
      rd1(5'd5, 0);
      if (i == 0) begin ex("sat_cyc_mid", S_CYC, 7); ex("sat_evt_mid", S_EVT, 1); end
      tick();
      rd1(5'd5, 1); tick();
    end
    idle(); ex("sat_cyc", S_CYC, 7); ex("sat_evt", S_EVT, 7); tick();

    tick();
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Pending-write scoreboard for the ID stage of the 5-stage pipeline. It records destination registers of loads issued into EX whose data has not yet returned from the data cache. It asserts a stall whenever the instruction in ID reads such a register. It complements the EX-stage forwarding logic: it covers the producer side that forwarding cannot, namely load results not yet available at the MEM/WB latch.

## Interface
- `MAX_LOADS`, default 2: maximum loads in flight between issue and data return.
- `CNT_W`, default 32: width of the performance counters.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `issue_i` input 1: the instruction in ID advances to EX this cycle.
- `issue_RegWrite_i` input 1: the issuing instruction writes a register.
- `issue_MemRead_i` input 1: the issuing instruction is a load.
- `issue_rd_i` input 5: destination of the issuing instruction.
- `rs1_ID_i`, `rs2_ID_i` input 5 each: source registers of the instruction in ID.
- `rs1_used_i`, `rs2_used_i` input 1 each: the source is actually read.
- `load_done_i` input 1: a load completes MEM this cycle; its data is captured into MEM/WB at this edge.
- `load_done_rd_i` input 5: destination of the completing load.
- `mem_stall_i` input 1: pipeline frozen by the data cache.
- `stall_o` output 1: hold PC and IF/ID, insert a bubble into ID/EX.
- `pending_o` output 32: scoreboard bitmap; bit 0 is always 0.
- `outstanding_o` output 2: loads in flight, range 0..`MAX_LOADS`.
- `overflow_o` output 1: sticky error flag.
- `stall_cycles_o` output `CNT_W`: count of hazard-stall cycles.
- `stall_events_o` output `CNT_W`: count of distinct stall episodes.

## Operation
- Define `set_en = issue_i & ~mem_stall_i & issue_RegWrite_i & issue_MemRead_i & (issue_rd_i != 0)`.
- Define `clr_en = load_done_i & (load_done_rd_i != 0)`.
- `pending[rd]` is set on `set_en` and cleared on `clr_en` for `load_done_rd_i`.
  - If set and clear target the same register in the same cycle, set wins.
  - Set and clear on different registers in the same cycle both take effect.
- Hazard on `rs1`: `rs1_used_i & (rs1_ID_i != 0) & pending[rs1_ID_i] & ~(clr_en & load_done_rd_i == rs1_ID_i)`.
- Hazard on `rs2`: same form, using `rs2`.
- `stall_o = hazard_rs1 | hazard_rs2`. The same-cycle clear bypass lets the dependent instruction reach EX together with the load reaching WB, where forwarding select 01 supplies the data.
- `stall_o` is combinational from registered state and current inputs. It is independent of `mem_stall_i`, since the freeze is the cache controller's concern.
- `issue_i` is ignored while `mem_stall_i` = 1.
- Outstanding counter:
  - Increments on a load issue (`set_en` without the rd≠0 term, i.e. `x0` loads still count).
  - Decrements on `load_done_i`.
  - When both occur in the same cycle, it is unchanged.
  - A decrement at 0 is ignored and sets `overflow_o`.
  - An increment at `MAX_LOADS` with no decrement holds the value and sets `overflow_o`.
- `overflow_o` clears only on reset.
- FSM with states RUN and HOLD:
  - RUN→HOLD when `stall_o` = 1 and `mem_stall_i` = 0; `stall_events_o` increments on this transition.
  - HOLD→RUN when `stall_o` = 0.
  - In HOLD, `mem_stall_i` does not change state.
- `stall_cycles_o` increments each cycle with `stall_o` = 1 and `mem_stall_i` = 0.
- Both counters saturate at all-ones.

## Timing
- Reset values: `pending_o` = 0, `outstanding_o` = 0, `overflow_o` = 0, both counters = 0, FSM in RUN, hence `stall_o` = 0.
- Reset mid-operation discards all pending bits in the same edge; inputs during reset have no effect.
- Set latency: a load issued at edge t makes `pending` visible in the cycle after t. A dependent instruction then in ID stalls immediately, giving the one-bubble load-use case.
- Clear latency: zero cycles, via the bypass in the `load_done_i` cycle. The register bit drops at the following edge.
- Cache miss: `load_done_i` is delayed, so `stall_o` stays high for the whole miss with no bit change.
- `pending_o[0]` and `x0` sources never stall.

## Test plan
- Load-use, cache hit: `ld x5` issued at cycle 1, `add x6,x5,x1` in ID at cycle 2 → `stall_o` = 1 in cycle 2. `load_done_i` with rd=5 in cycle 3 → `stall_o` = 0 in cycle 3. Finally `stall_cycles_o` = 1 and `stall_events_o` = 1.
- Cache miss: as above, but `load_done_i` arrives in cycle 12 with `mem_stall_i` = 1 during cycles 3–11 → `stall_o` = 1 during cycles 2–11, `stall_cycles_o` = 1, `pending_o[5]` cleared after cycle 12.
- Same-register collision: `set_en` rd=7 and `clr_en` rd=7 in the same cycle → `pending_o[7]` remains 1 and `outstanding_o` is unchanged.
- Zero and unused sources: `ld x0` issued → `pending_o` = 0 and `outstanding_o` = 1. A reader with `rs2_ID_i` = 9 but `rs2_used_i` = 0 while `pending[9]` = 1 → `stall_o` = 0.
- Overflow: three load issues with no done at `MAX_LOADS` = 2 → `outstanding_o` = 2 and `overflow_o` = 1, sticky until `rst_i`.
- Reset mid-stall: `rst_i` pulsed while `stall_o` = 1 → the next cycle `stall_o` = 0, `pending_o` = 0, counters = 0.
